hazard_stall_controller: RTL and testbench
==========================================

// Module: hazard_stall_controller
// PURPOSE
//  Central stall/flush sequencer for the 5-stage MIPS pipeline, next to the forwarding unit.
//  Detects load-use hazards forwarding cannot cover and branch-taken flushes.
//  Sequences the multi-cycle MULT/DIV unit with a busy FSM and latency counter.
//  Drives PC/IF-ID write enables and per-stage flushes; gates HI/LO ownership.
// PARAMETERS
//  MUL_LATENCY  4   cycles MULT occupies the HI/LO unit (1..2^CNT_W)
//  DIV_LATENCY  32  cycles DIV occupies the HI/LO unit (1..2^CNT_W)
//  CNT_W        6   latency down-counter width
// PORTS
//  clk               in   1   pipeline clock, all state on rising edge
//  reset             in   1   synchronous, active-high
//  IFID_RegisterRs   in   5   rs of instruction in ID
//  IFID_RegisterRt   in   5   rt of instruction in ID
//  IFID_UsesHiLo     in   1   ID instr is MFHI/MFLO/MTHI/MTLO/MULT/DIV
//  IDEX_MemRead      in   1   EX instr is a load
//  IDEX_RegisterRt   in   5   load destination in EX
//  IDEX_MulStart     in   1   EX instr is MULT
//  IDEX_DivStart     in   1   EX instr is DIV
//  EXMEM_BranchTaken in   1   branch/jump resolved taken in MEM
//  PCWrite           out  1   PC load enable
//  IFIDWrite         out  1   IF/ID register load enable
//  IFID_Flush        out  1   zero IF/ID on next edge
//  IDEX_Flush        out  1   bubble into ID/EX on next edge
//  EXMEM_Flush       out  1   bubble into EX/MEM on next edge
//  MD_Start          out  1   start accepted this cycle (pulse)
//  MD_Busy           out  1   HI/LO unit occupied
//  MD_Done           out  1   last busy cycle; HI/LO written at its closing edge
// BEHAVIOUR
//  Reset: state=RUN, cnt=0; while reset high PCWrite=0, IFIDWrite=0, all three flushes=1,
//   MD_Start=MD_Busy=MD_Done=0. Reset mid-BUSY aborts op; no MD_Done issued.
//  FSM RUN: start = (IDEX_MulStart|IDEX_DivStart) & !EXMEM_BranchTaken -> MD_Start=1,
//   cnt<=LAT-1 (MUL if MulStart, else DIV; both high => MUL), next BUSY.
//  FSM BUSY: MD_Busy=1; cnt decrements; cnt==0 -> MD_Done=1, next RUN. Start
//   inputs ignored in BUSY (ID stall prevents them). Busy spans exactly LAT cycles.
//  load_use = IDEX_MemRead & IDEX_RegisterRt!=0 &
//   (IDEX_RegisterRt==IFID_RegisterRs | IDEX_RegisterRt==IFID_RegisterRt).
//  hilo_stall = IFID_UsesHiLo & (state==BUSY | start); includes Done cycle; releases the
//   cycle after MD_Done.
//  Priority 1 EXMEM_BranchTaken: IFID_Flush=IDEX_Flush=EXMEM_Flush=1, PCWrite=IFIDWrite=1;
//   overrides any stall; wrong-path start in EX suppressed; running op continues.
//  Priority 2 stall (load_use|hilo_stall): PCWrite=0, IFIDWrite=0, IDEX_Flush=1.
//  Else: PCWrite=IFIDWrite=1, all flushes 0.
//  Decode outputs combinational from state+inputs, zero added latency; FSM/cnt registered.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined: adds output StallCycles[31:0]; +1 each cycle PCWrite=0
//   outside reset; saturates at 32'hFFFFFFFF; cleared by reset.
//  Undefined: port and counter absent; all other behaviour identical.
// TESTING
//  Load in EX rt=8, ID rs=8 -> one cycle PCWrite=0,IFIDWrite=0,IDEX_Flush=1; resume next.
//  Load rt=0 matching ID rs=0 -> no stall; all enables 1.
//  MulStart at T, MUL_LATENCY=4 -> MD_Busy T+1..T+4, MD_Done T+4; MFLO in ID stalls T..T+4.
//  DivStart with EXMEM_BranchTaken same cycle -> MD_Start=0, state RUN, three flushes=1.
//  Branch taken during load-use stall -> PCWrite=1, flushes=1, no stall that cycle.
//  Reset at 10th cycle of DIV -> next cycle MD_Busy=0, MD_Done never pulses, state RUN.

Source files
------------

// File: rtl/hazard_stall_controller_if.sv
// Pipeline hazard bundle between the decode-side stages and the stall/flush controller.
// Optional HAZARD_PERF_CNT_EN adds the StallCycles counter output.
interface hazard_stall_controller_if;
  logic [4:0] IFID_RegisterRs;
  logic [4:0] IFID_RegisterRt;
  logic       IFID_UsesHiLo;
  logic       IDEX_MemRead;
  logic [4:0] IDEX_RegisterRt;
  logic       IDEX_MulStart;
  logic       IDEX_DivStart;
  logic       EXMEM_BranchTaken;
  logic       PCWrite;
  logic       IFIDWrite;
  logic       IFID_Flush;
  logic       IDEX_Flush;
  logic       EXMEM_Flush;
  logic       MD_Start;
  logic       MD_Busy;
  logic       MD_Done;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] StallCycles;
`endif

  modport master (
    output IFID_RegisterRs, IFID_RegisterRt, IFID_UsesHiLo,
    output IDEX_MemRead, IDEX_RegisterRt,
    output IDEX_MulStart, IDEX_DivStart, EXMEM_BranchTaken,
    input  PCWrite, IFIDWrite,
    input  IFID_Flush, IDEX_Flush, EXMEM_Flush,
    input  MD_Start, MD_Busy, MD_Done
`ifdef HAZARD_PERF_CNT_EN
    , input StallCycles
`endif
  );

  modport slave (
    input  IFID_RegisterRs, IFID_RegisterRt, IFID_UsesHiLo,
    input  IDEX_MemRead, IDEX_RegisterRt,
    input  IDEX_MulStart, IDEX_DivStart, EXMEM_BranchTaken,
    output PCWrite, IFIDWrite,
    output IFID_Flush, IDEX_Flush, EXMEM_Flush,
    output MD_Start, MD_Busy, MD_Done
`ifdef HAZARD_PERF_CNT_EN
    , output StallCycles
`endif
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// Load-use / branch-flush / MULT-DIV busy sequencer for the 5-stage pipeline.
// Optional HAZARD_PERF_CNT_EN adds a saturating StallCycles counter.
module hazard_stall_controller #(
  parameter int MUL_LATENCY = 4,
  parameter int DIV_LATENCY = 32,
  parameter int CNT_W       = 6
) (
  input logic clk,
  input logic reset,
  hazard_stall_controller_if.slave hz
);

  typedef enum logic {RUN, BUSY} state_t;

  localparam logic [CNT_W-1:0] mulLoad = CNT_W'(MUL_LATENCY - 1);
  localparam logic [CNT_W-1:0] divLoad = CNT_W'(DIV_LATENCY - 1);

  state_t           state, nextState;
  logic [CNT_W-1:0] cnt, nextCnt;
  logic             start, busy, done;
  logic             loadUse, hiloStall, stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
    end
  end

  always_comb begin
    nextState = state;
    nextCnt   = cnt;
    start     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      RUN: begin
        // a taken branch means the MULT/DIV in EX is wrong-path
        start = (hz.IDEX_MulStart | hz.IDEX_DivStart)
              & ~hz.EXMEM_BranchTaken;
        if (start) begin
          nextState = BUSY;
          nextCnt   = hz.IDEX_MulStart ? mulLoad : divLoad;
        end
      end
      BUSY: begin
        busy = 1'b1;
        if (cnt == '0) begin
          done      = 1'b1;
          nextState = RUN;
        end else begin
          nextCnt = cnt - 1'b1;
        end
      end
      default: nextState = RUN;
    endcase
  end

  assign loadUse = hz.IDEX_MemRead
                 & (hz.IDEX_RegisterRt != 5'd0)
                 & ((hz.IDEX_RegisterRt == hz.IFID_RegisterRs)
                  | (hz.IDEX_RegisterRt == hz.IFID_RegisterRt));

  assign hiloStall = hz.IFID_UsesHiLo & ((state == BUSY) | start);
  assign stall     = loadUse | hiloStall;

  always_comb begin
    hz.PCWrite     = 1'b1;
    hz.IFIDWrite   = 1'b1;
    hz.IFID_Flush  = 1'b0;
    hz.IDEX_Flush  = 1'b0;
    hz.EXMEM_Flush = 1'b0;
    hz.MD_Start    = start & ~reset;
    hz.MD_Busy     = busy & ~reset;
    hz.MD_Done     = done & ~reset;
    if (reset) begin
      hz.PCWrite     = 1'b0;
      hz.IFIDWrite   = 1'b0;
      hz.IFID_Flush  = 1'b1;
      hz.IDEX_Flush  = 1'b1;
      hz.EXMEM_Flush = 1'b1;
    end else if (hz.EXMEM_BranchTaken) begin
      hz.IFID_Flush  = 1'b1;
      hz.IDEX_Flush  = 1'b1;
      hz.EXMEM_Flush = 1'b1;
    end else if (stall) begin
      hz.PCWrite    = 1'b0;
      hz.IFIDWrite  = 1'b0;
      hz.IDEX_Flush = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stallCnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      stallCnt <= '0;
    end else if (!hz.PCWrite && stallCnt != 32'hFFFF_FFFF) begin
      stallCnt <= stallCnt + 32'd1;
    end
  end

  assign hz.StallCycles = stallCnt;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed scoreboard bench for hazard_stall_controller (default latencies).
// Expected vector: {PCWrite,IFIDWrite,IFID_Flush,IDEX_Flush,EXMEM_Flush,MD_Start,MD_Busy,MD_Done}.
module tb_hazard_stall_controller;

  typedef struct packed {
    logic [7:0] e;
    logic       rst;
  } exp_t;

  localparam logic [7:0] NRM  = 8'b1100_0000;
  localparam logic [7:0] STL  = 8'b0001_0000;
  localparam logic [7:0] BRF  = 8'b1111_1000;
  localparam logic [7:0] RST  = 8'b0011_1000;
  localparam logic [7:0] ST   = 8'b0000_0100;
  localparam logic [7:0] BSY  = 8'b0000_0010;
  localparam logic [7:0] DN   = 8'b0000_0011;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t q[$];

  hazard_stall_controller_if hz ();

  hazard_stall_controller dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  always #5 clk = ~clk;

  task automatic step(
    input logic [4:0] rs, rt,
    input logic       hl, mr,
    input logic [4:0] er,
    input logic       mul, div, br, rst,
    input logic [7:0] e
  );
    @(posedge clk);
    #1;
    hz.IFID_RegisterRs   = rs;
    hz.IFID_RegisterRt   = rt;
    hz.IFID_UsesHiLo     = hl;
    hz.IDEX_MemRead      = mr;
    hz.IDEX_RegisterRt   = er;
    hz.IDEX_MulStart     = mul;
    hz.IDEX_DivStart     = div;
    hz.EXMEM_BranchTaken = br;
    reset                = rst;
    q.push_back('{e: e, rst: rst});
  endtask

  task automatic idle(input logic [7:0] e);
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, e);
  endtask

  task automatic hilo(input logic [7:0] e);
    step(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, e);
  endtask

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perfModel = '0;
  bit          perfValid = 1'b0;
`endif

  always @(negedge clk) begin
    exp_t       x;
    logic [7:0] got;
    cyc++;
    if (q.size() != 0) begin
      x   = q.pop_front();
      got = {hz.PCWrite, hz.IFIDWrite, hz.IFID_Flush, hz.IDEX_Flush,
             hz.EXMEM_Flush, hz.MD_Start, hz.MD_Busy, hz.MD_Done};
      checks++;
      if (got !== x.e) begin
        errors++;
        $display("FAIL outputs cyc %0d got %b exp %b", cyc, got, x.e);
      end
`ifdef HAZARD_PERF_CNT_EN
      if (perfValid) begin
        checks++;
        if (hz.StallCycles !== perfModel) begin
          errors++;
          $display("FAIL StallCycles cyc %0d got %0d exp %0d",
                   cyc, hz.StallCycles, perfModel);
        end
      end
      if (x.rst) begin
        perfModel = '0;
        perfValid = 1'b1;
      end else if (!x.e[7]) begin
        perfModel = perfModel + 32'd1;
      end
`endif
    end
  end

  initial begin
    hz.IFID_RegisterRs   = '0;
    hz.IFID_RegisterRt   = '0;
    hz.IFID_UsesHiLo     = 1'b0;
    hz.IDEX_MemRead      = 1'b0;
    hz.IDEX_RegisterRt   = '0;
    hz.IDEX_MulStart     = 1'b0;
    hz.IDEX_DivStart     = 1'b0;
    hz.EXMEM_BranchTaken = 1'b0;

    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, RST);
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, RST);
    idle(NRM);
    // load-use on rs, then on rt, then r0 exempt
    step(5'd8, 5'd3, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, STL);
    step(5'd8, 5'd3, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NRM);
    step(5'd4, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, STL);
    step(5'd4, 5'd5, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, NRM);
    step(5'd0, 5'd7, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NRM);
    step(5'd8, 5'd3, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0, BRF);
    // MULT with MFLO in ID: stall T..T+4
    step(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, STL | ST);
    hilo(STL | BSY);
    hilo(STL | BSY);
    hilo(STL | BSY);
    hilo(STL | DN);
    hilo(NRM);
    // MULT without HI/LO user; branch and stray start mid-busy
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, NRM | ST);
    idle(NRM | BSY);
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, BRF | BSY);
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, NRM | BSY);
    idle(NRM | DN);
    idle(NRM);
    // wrong-path DIV suppressed by branch
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, BRF);
    idle(NRM);
    idle(NRM);
    // both starts: MUL latency wins
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, NRM | ST);
    for (int i = 0; i < 3; i++) idle(NRM | BSY);
    idle(NRM | DN);
    idle(NRM);
    // full DIV, 32 busy cycles
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, NRM | ST);
    for (int i = 0; i < 31; i++) idle(NRM | BSY);
    idle(NRM | DN);
    idle(NRM);
    // DIV aborted by reset on its 10th busy cycle
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, NRM | ST);
    for (int i = 0; i < 9; i++) idle(NRM | BSY);
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, RST);
    for (int i = 0; i < 30; i++) idle(NRM);
    step(5'd6, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, STL);
    idle(NRM);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d exp 0", q.size());
    end
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
